// File: rtl/xbee_gps_pkg.sv
// rtl/xbee_gps_pkg.sv - shared state encoding, select constants and timing helper
package xbee_gps_pkg;

  typedef enum logic [1:0] {
    STABLE     = 2'd0,
    WAIT_QUIET = 2'd1,
    SWITCH     = 2'd2,
    GUARD      = 2'd3
  } state_t;

  localparam logic SEL_GPS  = 1'b0;
  localparam logic SEL_XBEE = 1'b1;

  // Clock cycles per UART bit; integer division, caller keeps it >= 2.
  function automatic int bit_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/xbee_gps_select_ctrl_sync_2ff.sv
// rtl/xbee_gps_select_ctrl_sync_2ff.sv - two-flop synchronizer with configurable reset value
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both load RESET_VAL so an idle line reads idle out of reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/xbee_gps_select_ctrl.sv
// rtl/xbee_gps_select_ctrl.sv - Xbee/GPS mux select sequencer; optional forced switch via FORCE_SWITCH_EN
module xbee_gps_select_ctrl
  import xbee_gps_pkg::*;
#(
  parameter int CLK_HZ             = 50000000,
  parameter int BAUD               = 9600,
  parameter int IDLE_BITS          = 12,
  parameter int GUARD_BITS         = 2,
  parameter int FORCE_TIMEOUT_BITS = 1000
) (
  input  logic Clk,
  input  logic RstN,
  input  logic SelReq,
  input  logic RPITx,
  input  logic GpsTx,
  input  logic XbeeTx,
  output logic XbeeGpsSelect,
  output logic Switching,
  output logic SwitchDone,
  output logic ForcedSwitch
);

  localparam int BIT_CYCLES  = bit_cycles(CLK_HZ, BAUD);
  localparam int IDLE_LIMIT  = IDLE_BITS * BIT_CYCLES;
  localparam int GUARD_LIMIT = GUARD_BITS * BIT_CYCLES;
  localparam int QW          = $clog2(IDLE_LIMIT + 1);
  localparam int GW          = $clog2(GUARD_LIMIT + 1);

  localparam logic [QW-1:0] IDLE_MAX   = QW'(IDLE_LIMIT);
  localparam logic [QW-1:0] IDLE_LAST  = QW'(IDLE_LIMIT - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_LIMIT - 1);

  logic req_s;
  logic rpi_s;
  logic gps_s;
  logic xbee_s;

  state_t state_q;
  state_t state_d;

  logic          sel_q;
  logic          done_q;
  logic          quiet;
  logic          quiet_done;
  logic          guard_done;
  logic          timeout_done;
  logic          entering;
  logic [QW-1:0] quiet_cnt;
  logic [GW-1:0] guard_cnt;

  // The request idles at GPS and the UART lines idle high out of reset.
  sync_2ff #(.RESET_VAL(1'b0)) u_sync_req  (.clk(Clk), .resetn(RstN), .d(SelReq), .q(req_s));
  sync_2ff #(.RESET_VAL(1'b1)) u_sync_rpi  (.clk(Clk), .resetn(RstN), .d(RPITx),  .q(rpi_s));
  sync_2ff #(.RESET_VAL(1'b1)) u_sync_gps  (.clk(Clk), .resetn(RstN), .d(GpsTx),  .q(gps_s));
  sync_2ff #(.RESET_VAL(1'b1)) u_sync_xbee (.clk(Clk), .resetn(RstN), .d(XbeeTx), .q(xbee_s));

  assign quiet      = rpi_s & gps_s & xbee_s;
  // The quiet window completes on the cycle the count would reach the limit.
  assign quiet_done = quiet && (quiet_cnt == IDLE_LAST);
  assign guard_done = (guard_cnt == GUARD_LAST);
  assign entering   = (state_d != state_q);

  // Next-state selection; withdrawal of the request beats any switch decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STABLE: begin
        if (req_s != sel_q) state_d = WAIT_QUIET;
      end
      WAIT_QUIET: begin
        if (req_s == sel_q)                  state_d = STABLE;
        else if (quiet_done || timeout_done) state_d = SWITCH;
      end
      SWITCH: begin
        state_d = GUARD;
      end
      GUARD: begin
        if (guard_done) state_d = STABLE;
      end
      default: begin
        state_d = STABLE;
      end
    endcase
  end

  // State, select flop and done pulse; the target is latched as "the other side" so late request edges are ignored.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state_q <= STABLE;
      sel_q   <= SEL_GPS;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == GUARD) && guard_done;
      if (state_q == SWITCH) begin
        sel_q <= (sel_q == SEL_GPS) ? SEL_XBEE : SEL_GPS;
      end
    end
  end

  // Quiet window counter: any low line restarts the window in full; saturates at the limit.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      quiet_cnt <= '0;
    end else if (entering || (state_q != WAIT_QUIET) || !quiet) begin
      quiet_cnt <= '0;
    end else if (quiet_cnt != IDLE_MAX) begin
      quiet_cnt <= quiet_cnt + QW'(1);
    end
  end

  // Guard counter: runs only while holding the new select.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      guard_cnt <= '0;
    end else if (entering || (state_q != GUARD)) begin
      guard_cnt <= '0;
    end else if (!guard_done) begin
      guard_cnt <= guard_cnt + GW'(1);
    end
  end

`ifdef FORCE_SWITCH_EN
  localparam int TIMEOUT_LIMIT = FORCE_TIMEOUT_BITS * BIT_CYCLES;
  localparam int TW            = $clog2(TIMEOUT_LIMIT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_LIMIT - 1);

  logic [TW-1:0] timeout_cnt;
  logic          force_pend;
  logic          forced_q;

  assign timeout_done = (state_q == WAIT_QUIET) && (timeout_cnt == TIMEOUT_LAST);

  // Timeout counter: every cycle spent waiting for quiet, regardless of line activity.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      timeout_cnt <= '0;
    end else if (entering || (state_q != WAIT_QUIET)) begin
      timeout_cnt <= '0;
    end else if (!timeout_done) begin
      timeout_cnt <= timeout_cnt + TW'(1);
    end
  end

  // Remember why we left WAIT_QUIET; a coincident quiet completion counts as a normal switch.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      force_pend <= 1'b0;
      forced_q   <= 1'b0;
    end else begin
      if ((state_q == WAIT_QUIET) && (state_d == SWITCH)) begin
        force_pend <= !quiet_done;
      end
      if (state_q == SWITCH) begin
        forced_q <= force_pend;
      end
    end
  end

  assign ForcedSwitch = forced_q;
`else
  logic cfg_unused;

  assign cfg_unused   = (FORCE_TIMEOUT_BITS > 0);
  assign timeout_done = 1'b0;
  assign ForcedSwitch = 1'b0;
`endif

  assign XbeeGpsSelect = sel_q;
  assign Switching     = (state_q != STABLE);
  assign SwitchDone    = done_q;

endmodule

// File: tb/tb_xbee_gps_select_ctrl.sv
// tb/tb_xbee_gps_select_ctrl.sv - directed and randomized checks of xbee_gps_select_ctrl against a reference model
module tb_xbee_gps_select_ctrl;

  localparam int CLK_HZ    = 1000000;
  localparam int BAUD      = 100000;
  localparam int IDLE_BITS = 12;
  localparam int GUARD_BITS = 2;
  localparam int FT_BITS   = 20;
  localparam int BITC      = CLK_HZ / BAUD;
  localparam int IDLE_CYC  = IDLE_BITS * BITC;
  localparam int GUARD_CYC = GUARD_BITS * BITC;
  localparam int TO_CYC    = FT_BITS * BITC;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sel_req = 1'b0;
  logic rpi = 1'b1;
  logic gps = 1'b1;
  logic xb = 1'b1;
  logic sel_o;
  logic switching;
  logic done;
  logic forced;

  int vectors = 0;
  int miscompares = 0;

  // Model: inputs seen by the controller after two cycles, a pending request with
  // its quiet/timeout run lengths, a one-cycle commit, then a countdown hold.
  bit r_d1, r_d2, q_d1, q_d2;
  bit m_pending, m_fire, m_fire_forced, m_sel, m_done, m_forced;
  int m_qrun, m_trun, m_hold;

  int cyc, rise_cyc, done_cyc, done_cnt, first_sw;
  bit prev_sel;

  xbee_gps_select_ctrl #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .IDLE_BITS(IDLE_BITS),
    .GUARD_BITS(GUARD_BITS), .FORCE_TIMEOUT_BITS(FT_BITS)
  ) dut (
    .Clk(clk), .RstN(rstn), .SelReq(sel_req), .RPITx(rpi), .GpsTx(gps), .XbeeTx(xb),
    .XbeeGpsSelect(sel_o), .Switching(switching), .SwitchDone(done), .ForcedSwitch(forced)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst_n, input bit req, input bit lines_high);
    if (!rst_n) begin
      r_d1 = 0; r_d2 = 0; q_d1 = 1; q_d2 = 1;
      m_pending = 0; m_fire = 0; m_fire_forced = 0; m_sel = 0; m_done = 0; m_forced = 0;
      m_qrun = 0; m_trun = 0; m_hold = 0;
    end else begin
      m_done = 0;
      if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_done = 1;
      end else if (m_fire) begin
        m_sel = !m_sel;
        m_forced = m_fire_forced;
        m_fire = 0;
        m_hold = GUARD_CYC;
      end else if (m_pending) begin
        if (r_d2 == m_sel) begin
          m_pending = 0;
        end else begin
          m_qrun = q_d2 ? m_qrun + 1 : 0;
          m_trun++;
          if (m_qrun == IDLE_CYC) begin
            m_pending = 0; m_fire = 1; m_fire_forced = 0;
          end
`ifdef FORCE_SWITCH_EN
          else if (m_trun == TO_CYC) begin
            m_pending = 0; m_fire = 1; m_fire_forced = 1;
          end
`endif
        end
      end else if (r_d2 != m_sel) begin
        m_pending = 1; m_qrun = 0; m_trun = 0;
      end
      r_d2 = r_d1; r_d1 = req;
      q_d2 = q_d1; q_d1 = lines_high;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rstn, sel_req, rpi & gps & xb);
    #1;
    cyc++;
    check("select", sel_o, m_sel);
    check("switching", switching, m_pending || m_fire || (m_hold > 0));
    check("done", done, m_done);
    check("forced", forced, m_forced);
    if (sel_o && !prev_sel && rise_cyc < 0) rise_cyc = cyc;
    prev_sel = sel_o;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (switching && first_sw < 0) first_sw = cyc;
  endtask

  task automatic start_case();
    rstn = 0; sel_req = 0; rpi = 1; gps = 1; xb = 1;
    tick();
    tick();
    rstn = 1;
    cyc = 0; rise_cyc = -1; done_cyc = -1; done_cnt = 0; first_sw = -1;
    prev_sel = sel_o;
  endtask

  initial begin
    // Reset state
    start_case();
    check("rst_select", sel_o, 0);
    check("rst_switching", switching, 0);
    check("rst_done", done, 0);
    check("rst_forced", forced, 0);

    // Plain switch to Xbee with all lines idle
    sel_req = 1;
    repeat (160) tick();
    check("sw_rise_cycle", first_sw, 3);
    check("sel_rise_cycle", rise_cyc, 124);
    check("done_cycle", done_cyc, 144);
    check("done_count", done_cnt, 1);

    // One-cycle glitch on GpsTx restarts the quiet window
    start_case();
    sel_req = 1;
    repeat (62) tick();
    gps = 0;
    tick();
    gps = 1;
    repeat (160) tick();
    check("glitch_rise_cycle", rise_cyc, 63 + 2 + IDLE_CYC + 1);

    // Request withdrawn while waiting for quiet
    start_case();
    sel_req = 1;
    repeat (50) tick();
    sel_req = 0;
    repeat (200) tick();
    check("withdraw_select", sel_o, 0);
    check("withdraw_rise", rise_cyc, -1);
    check("withdraw_done", done_cnt, 0);

    // Request flips back during GUARD; picked up right after SwitchDone
    start_case();
    sel_req = 1;
    repeat (130) tick();
    sel_req = 0;
    while (cyc < 300) begin
      tick();
      if (cyc == 144) check("guard_sw_low", switching, 0);
      if (cyc == 145) check("guard_reenter", switching, 1);
    end
    check("guard_second_done", done_cnt, 2);
    check("guard_final_select", sel_o, 0);

    // Reset pulse during GUARD
    start_case();
    sel_req = 1;
    repeat (130) tick();
    rstn = 0;
    sel_req = 0;
    tick();
    check("midrst_select", sel_o, 0);
    check("midrst_switching", switching, 0);
    rstn = 1;
    repeat (40) tick();
    check("midrst_done", done_cnt, 0);

`ifdef FORCE_SWITCH_EN
    // Busy RPITx forces the switch after the timeout; a later quiet switch clears the flag
    start_case();
    sel_req = 1;
    while (cyc < 260) begin
      rpi = ((cyc / 5) % 2) == 0;
      tick();
    end
    check("force_rise_cycle", rise_cyc, 3 + TO_CYC + 1);
    check("force_flag", forced, 1);
    rpi = 1;
    sel_req = 0;
    repeat (300) tick();
    check("force_cleared", forced, 0);
    check("force_back_select", sel_o, 0);
`endif

    // Randomized traffic: alternating busy and quiet stretches, random requests and rare resets
    start_case();
    begin
      bit noisy = 0;
      for (int i = 0; i < 8000; i++) begin
        if (i % 250 == 0) noisy = ($urandom_range(0, 2) == 0);
        if (noisy) begin
          rpi = ($urandom_range(0, 7) != 0);
          gps = ($urandom_range(0, 7) != 0);
          xb  = ($urandom_range(0, 7) != 0);
        end else begin
          rpi = ($urandom_range(0, 499) != 0);
          gps = 1;
          xb  = ($urandom_range(0, 499) != 0);
        end
        if ($urandom_range(0, 149) == 0) sel_req = !sel_req;
        rstn = ($urandom_range(0, 2999) != 0);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xbee_gps_select_ctrl.md
Name: xbee_gps_select_ctrl

Overview:
- Upstream control stage for the Xbee/GPS UART steering mux. It generates the mux select line from the Raspberry Pi's raw select request.
- The change is applied only when every UART line involved is idle, so no frame is split across peripherals.
- It synchronizes all asynchronous inputs, waits for a quiet window, flips the select, then holds it for a guard time.
- It reports busy and completion status back to the Pi.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, UART bit rate. BIT_CYCLES = CLK_HZ/BAUD, integer division; must be >= 2.
- IDLE_BITS, 12, number of bit-times all watched lines must stay high before a switch.
- GUARD_BITS, 2, number of bit-times the new select is held before another request is accepted.
- FORCE_TIMEOUT_BITS, 1000, bit-times to wait for quiet before a forced switch. Used only with FORCE_SWITCH_EN.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- RstN  in  1  reset, synchronous, active-low.
- SelReq  in  1  asynchronous request from Pi: 1 = Xbee, 0 = GPS.
- RPITx  in  1  asynchronous Pi UART Tx, monitored only.
- GpsTx  in  1  asynchronous GPS UART Tx, monitored only.
- XbeeTx  in  1  asynchronous Xbee UART Tx, monitored only.
- XbeeGpsSelect  out  1  registered select to the steering mux: 1 = Xbee, 0 = GPS.
- Switching  out  1  high while a requested change is pending or in guard.
- SwitchDone  out  1  one-cycle pulse at the end of guard.
- ForcedSwitch  out  1  sticky flag: the last switch was forced (see Optional Feature).

Behaviour:
- Synchronization
  - SelReq, RPITx, GpsTx and XbeeTx each pass through a 2-flop synchronizer.
  - On reset, the Tx synchronizers load 1 and SelReq loads 0.
  - Input to state-machine latency is 2 cycles.
- Reset values: XbeeGpsSelect=0, Switching=0, SwitchDone=0, ForcedSwitch=0, counters 0, state STABLE.
- Quiet condition: synchronized RPITx, GpsTx and XbeeTx are all 1.
- QuietCnt
  - Increments by 1 each cycle the quiet condition holds, in WAIT_QUIET only.
  - Clears to 0 on any cycle where any watched line is 0, and on every state entry.
  - Saturates at IDLE_BITS*BIT_CYCLES. Width is $clog2(IDLE_BITS*BIT_CYCLES+1).
- States:
  - STABLE: Switching=0. If sync SelReq != XbeeGpsSelect, go to WAIT_QUIET.
  - WAIT_QUIET: Switching=1.
    - If sync SelReq == XbeeGpsSelect (request withdrawn), return to STABLE with no switch and no SwitchDone.
    - Else, when QuietCnt reaches IDLE_BITS*BIT_CYCLES, go to SWITCH.
  - SWITCH: single cycle. XbeeGpsSelect <= sync SelReq, ForcedSwitch <= 0, go to GUARD.
  - GUARD: Switching=1. GuardCnt counts GUARD_BITS*BIT_CYCLES cycles. On the terminal cycle, pulse SwitchDone and go to STABLE.
- SelReq changes during SWITCH or GUARD are ignored. The request is level-sensitive and is re-evaluated in STABLE on the cycle after SwitchDone.
- A line glitching low for one cycle restarts the quiet window in full.
- RstN low mid-operation: all state returns to reset values on the next edge, including XbeeGpsSelect, which reverts to GPS.
- XbeeGpsSelect changes only on the SWITCH cycle or on reset, and is glitch-free because it is a flop output.

Optional Feature:
- Macro: FORCE_SWITCH_EN.
- With the macro defined:
  - A TimeoutCnt runs in WAIT_QUIET and clears on state entry.
  - When TimeoutCnt reaches FORCE_TIMEOUT_BITS*BIT_CYCLES, go to SWITCH regardless of QuietCnt.
  - On that switch, ForcedSwitch is set to 1. It clears on the next normal SWITCH or on reset.
  - If the quiet window and the timeout complete on the same cycle, the switch is treated as normal (ForcedSwitch=0).
- Without the macro: no TimeoutCnt, ForcedSwitch is tied to 0, and WAIT_QUIET can wait indefinitely.

Decomposition:
- Shared package xbee_gps_pkg holds:
  - state enum {STABLE, WAIT_QUIET, SWITCH, GUARD};
  - constants SEL_GPS=1'b0 and SEL_XBEE=1'b1;
  - function bit_cycles(clk_hz, baud).
- One sub-module: sync_2ff, parameterized by reset value, instantiated four times.

Test Plan (CLK_HZ=1000000, BAUD=100000, so BIT_CYCLES=10; IDLE_BITS=12, GUARD_BITS=2):
- Reset, then all lines high and SelReq 0->1 at cycle 0 -> Switching rises at cycle 3, XbeeGpsSelect=1 at cycle 124, SwitchDone pulses once at cycle 144.
- GpsTx pulled low 1 cycle at cycle 60 of the quiet window -> window restarts; XbeeGpsSelect rises 120 quiet cycles after the glitch.
- SelReq 0->1, then back to 0 after 50 cycles -> return to STABLE; XbeeGpsSelect stays 0; no SwitchDone.
- SelReq toggles 1->0 during GUARD -> ignored until SwitchDone; the next cycle enters WAIT_QUIET, and a second switch back to GPS completes.
- RstN low for 1 cycle during GUARD after a switch to Xbee -> XbeeGpsSelect=0, Switching=0, no SwitchDone.
- FORCE_SWITCH_EN with FORCE_TIMEOUT_BITS=20 and RPITx toggling every 5 cycles -> switch at 200 cycles in WAIT_QUIET, ForcedSwitch=1; a later quiet switch clears it.
